ifmap_feeder: RTL and testbench
===============================

Name: ifmap_feeder

Overview:
- Sequencer that drives one PE row's ifmap unicast chain and weight broadcast bus from the global buffer.
- On start it does four things in order:
  - clears the PE weights;
  - streams G_KERNEL_SIZE weights;
  - streams the full image in raster order, with the alternating row flag the PEs use to detect row boundaries;
  - reports done.
- It is the transmit end of the PE's ifmap_*/weight_* inputs.

Parameters:
G_BUF_ADDR_WIDTH, 10, global buffer address width
G_BUF_DATA_WIDTH, 8, global buffer word width (pixel/weight)
G_TOP_BITS, 2, integer bits (incl. sign) of fixed-point output
G_BOT_BITS, 14, fraction bits of fixed-point output (must be >= G_BUF_DATA_WIDTH)
G_KERNEL_SIZE, 5, weights per load
G_IMAGE_HEIGHT, 28, image rows
G_IMAGE_WIDTH, 28, image columns

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start pulse, honoured only in IDLE
wgt_base_i  in  G_BUF_ADDR_WIDTH  weight base address, captured at start
ifmap_base_i  in  G_BUF_ADDR_WIDTH  image base address, captured at start
stall_i  in  1  pause: no new buffer read issued while high
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse at job end
buf_rd_en_o  out  1  buffer read strobe
buf_rd_addr_o  out  G_BUF_ADDR_WIDTH  buffer read address
buf_rd_data_i  in  G_BUF_DATA_WIDTH  read data, valid 1 cycle after strobe
weight_clr_o  out  1  PE weight clear
weight_vld_o  out  1  weight valid
weight_o  out  G_TOP_BITS+G_BOT_BITS  weight, signed fixed point
ifmap_vld_o  out  1  ifmap valid
ifmap_row_o  out  1  row parity flag
ifmap_o  out  G_TOP_BITS+G_BOT_BITS  pixel, fixed point

Behaviour:
- Reset (async): state IDLE, all counters 0; every output 0.
- Reset mid-job aborts immediately; in-flight reads are discarded.
- States and transitions:
  - IDLE: start_i=1 captures both bases -> WCLR. start_i in any other state is ignored.
  - WCLR: weight_clr_o=1 for exactly one cycle -> WLOAD.
  - WLOAD: issues reads at wgt_base+k, k=0..K-1 -> IFMAP after read K-1 issues.
  - IFMAP: issues reads at ifmap_base+r*W+c in raster order -> DRAIN after the H*W-th read.
  - DRAIN: exactly 2 cycles -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE.
- Addresses are computed modulo 2^G_BUF_ADDR_WIDTH (wrap).
- Read strobe: buf_rd_en_o = (state in WLOAD/IFMAP) & ~stall_i. The address is combinational from the counters. Counters advance only on an issued read.
- Output pipeline:
  - Read issued in cycle n; data arrives in n+1; registered output valid in n+2.
  - A 2-stage tag pipeline (valid, is_weight, row parity) follows each read.
  - stall_i affects output valid 2 cycles later; reads already in flight always complete.
- Weight conversion: signed 8-bit w -> sign-extend, shift left by G_BOT_BITS-(G_BUF_DATA_WIDTH-1) (Q1.7 -> Q2.14).
  - Word k lands in PE weight slot k after K pushes (first sent shifts furthest).
- Pixel conversion: unsigned p -> zero-extend, shift left by G_BOT_BITS-G_BUF_DATA_WIDTH (value p/256).
- Row flag: ifmap_row_o = ~r[0] for pixels of image row r (row 0 = 1, row 1 = 0, ...).
- Hold behaviour while the corresponding valid is low:
  - ifmap_o and ifmap_row_o hold their last values.
  - weight_o holds its last value.
- Weight and ifmap valids are never high in the same cycle.
- Only the final pixel can be in flight at the transition to DRAIN, so DRAIN's 2 cycles fully empty the pipeline.

Test Plan:
- Default parameters, no stall, start_i at cycle 0 -> expected timeline:
  - weight_clr_o in cycle 1;
  - reads issued cycles 2-6 (weights) and 7-790 (pixels);
  - weight_vld_o in cycles 4-8;
  - ifmap_vld_o in cycles 9-792;
  - done_o in cycle 793;
  - busy_o high in cycles 1-793.
- Conversion: weight bytes 0x80, 0x7F, 0x00, 0xFF, 0x01 -> weight_o 0xC000, 0x3F80, 0x0000, 0xFF80, 0x0080. Pixels 0xFF and 0x80 -> ifmap_o 0x3FC0 and 0x2000.
- Row flag: ifmap_row_o=1 for the first 28 valid pixels, 0 for the next 28, alternating; the 784th pixel has flag 0.
- stall_i high for 3 cycles mid-image -> exactly 3 fewer reads in that window, then a 3-cycle gap in ifmap_vld_o 2 cycles later. Pixel sequence is unbroken and in order; done_o is delayed by 3.
- ifmap_base_i=1020 -> addresses 1020-1023 then wrap to 0. start_i pulsed while busy -> ignored.
- rst_i asserted asynchronously mid-IFMAP -> all outputs 0 immediately. A fresh start replays from weight clear.

Source files
------------

// File: rtl/ifmap_feeder.sv
// Global-buffer sequencer for one PE row: clears PE weights, loads a kernel,
// then streams the image in raster order with an alternating row-parity flag.
module ifmap_feeder #(
  parameter int G_BUF_ADDR_WIDTH = 10,
  parameter int G_BUF_DATA_WIDTH = 8,
  parameter int G_TOP_BITS       = 2,
  parameter int G_BOT_BITS       = 14,
  parameter int G_KERNEL_SIZE    = 5,
  parameter int G_IMAGE_HEIGHT   = 28,
  parameter int G_IMAGE_WIDTH    = 28
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]          wgt_base_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]          ifmap_base_i,
  input  logic                                 stall_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 buf_rd_en_o,
  output logic [G_BUF_ADDR_WIDTH-1:0]          buf_rd_addr_o,
  input  logic [G_BUF_DATA_WIDTH-1:0]          buf_rd_data_i,
  output logic                                 weight_clr_o,
  output logic                                 weight_vld_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]     weight_o,
  output logic                                 ifmap_vld_o,
  output logic                                 ifmap_row_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]     ifmap_o
);

  localparam int AW   = G_BUF_ADDR_WIDTH;
  localparam int DW   = G_BUF_DATA_WIDTH;
  localparam int OW   = G_TOP_BITS + G_BOT_BITS;
  localparam int KW   = (G_KERNEL_SIZE > 1) ? $clog2(G_KERNEL_SIZE) : 1;
  localparam int RW   = (G_IMAGE_HEIGHT > 1) ? $clog2(G_IMAGE_HEIGHT) : 1;
  localparam int CW   = (G_IMAGE_WIDTH > 1) ? $clog2(G_IMAGE_WIDTH) : 1;
  localparam int NPIX = G_IMAGE_HEIGHT * G_IMAGE_WIDTH;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WSH  = G_BOT_BITS - (DW - 1);
  localparam int PSH  = G_BOT_BITS - DW;

  typedef enum logic [2:0] {IDLE, WCLR, WLOAD, IFMAP, DRAIN, DONE} state_e;

  state_e          state_q;
  logic [AW-1:0]   wgtBase_q, ifmapBase_q;
  logic [KW-1:0]   kCnt_q;
  logic [RW-1:0]   rowCnt_q;
  logic [CW-1:0]   colCnt_q;
  logic [PW-1:0]   pixCnt_q;
  logic            drainCnt_q, busy_q, clr_q, done_q;
  logic            tagVld_q, tagWgt_q, tagRow_q;
  logic            wVld_q, iVld_q, iRow_q;
  logic [OW-1:0]   weight_q, ifmap_q;
  logic            rdEn;
  logic [AW-1:0]   rdAddr;
  logic [OW-1:0]   weightConv, pixelConv;

  assign rdEn = ((state_q == WLOAD) || (state_q == IFMAP)) && !stall_i;

  // Linear pixel offset avoids a multiplier; the cast gives modulo-2^AW wrap.
  always_comb begin
    rdAddr = '0;
    if (state_q == WLOAD)      rdAddr = wgtBase_q + AW'(kCnt_q);
    else if (state_q == IFMAP) rdAddr = ifmapBase_q + AW'(pixCnt_q);
  end

  assign weightConv = {{(OW-DW){buf_rd_data_i[DW-1]}}, buf_rd_data_i} << WSH;
  assign pixelConv  = {{(OW-DW){1'b0}}, buf_rd_data_i} << PSH;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wgtBase_q   <= '0;
      ifmapBase_q <= '0;
      kCnt_q      <= '0;
      rowCnt_q    <= '0;
      colCnt_q    <= '0;
      pixCnt_q    <= '0;
      drainCnt_q  <= 1'b0;
      busy_q      <= 1'b0;
      clr_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            wgtBase_q   <= wgt_base_i;
            ifmapBase_q <= ifmap_base_i;
            kCnt_q      <= '0;
            rowCnt_q    <= '0;
            colCnt_q    <= '0;
            pixCnt_q    <= '0;
            state_q     <= WCLR;
            clr_q       <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        WCLR: state_q <= WLOAD;
        WLOAD: begin
          if (rdEn) begin
            if (kCnt_q == KW'(G_KERNEL_SIZE - 1)) begin
              kCnt_q  <= '0;
              state_q <= IFMAP;
            end else begin
              kCnt_q <= kCnt_q + 1'b1;
            end
          end
        end
        IFMAP: begin
          if (rdEn) begin
            pixCnt_q <= pixCnt_q + 1'b1;
            if (colCnt_q == CW'(G_IMAGE_WIDTH - 1)) begin
              colCnt_q <= '0;
              if (rowCnt_q == RW'(G_IMAGE_HEIGHT - 1)) begin
                rowCnt_q   <= '0;
                pixCnt_q   <= '0;
                drainCnt_q <= 1'b0;
                state_q    <= DRAIN;
              end else begin
                rowCnt_q <= rowCnt_q + 1'b1;
              end
            end else begin
              colCnt_q <= colCnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drainCnt_q) begin
            drainCnt_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            drainCnt_q <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag travels alongside the buffer read so returning data knows its kind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tagVld_q <= 1'b0;
      tagWgt_q <= 1'b0;
      tagRow_q <= 1'b0;
      wVld_q   <= 1'b0;
      iVld_q   <= 1'b0;
      iRow_q   <= 1'b0;
      weight_q <= '0;
      ifmap_q  <= '0;
    end else begin
      tagVld_q <= rdEn;
      tagWgt_q <= (state_q == WLOAD);
      tagRow_q <= ~rowCnt_q[0];
      wVld_q   <= tagVld_q && tagWgt_q;
      iVld_q   <= tagVld_q && !tagWgt_q;
      if (tagVld_q && tagWgt_q) weight_q <= weightConv;
      if (tagVld_q && !tagWgt_q) begin
        ifmap_q <= pixelConv;
        iRow_q  <= tagRow_q;
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign weight_clr_o  = clr_q;
  assign buf_rd_en_o   = rdEn;
  assign buf_rd_addr_o = rdAddr;
  assign weight_vld_o  = wVld_q;
  assign weight_o      = weight_q;
  assign ifmap_vld_o   = iVld_q;
  assign ifmap_row_o   = iRow_q;
  assign ifmap_o       = ifmap_q;

endmodule

// File: tb/tb_ifmap_feeder.sv
// Randomized bench for ifmap_feeder: a buffer model feeds the DUT and every
// stream, address and timing point is compared with a simple arithmetic model.
module tb_ifmap_feeder;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int TOP    = 2;
  localparam int BOT    = 14;
  localparam int K      = 5;
  localparam int H      = 28;
  localparam int W      = 28;
  localparam int OW     = TOP + BOT;
  localparam int NPIX   = H * W;
  localparam int JOBLEN = 1 + K + NPIX + 2 + 1;

  logic          clk = 1'b0;
  logic          rst_i, start_i, stall_i;
  logic [AW-1:0] wgt_base_i, ifmap_base_i;
  logic          busy_o, done_o, buf_rd_en_o;
  logic [AW-1:0] buf_rd_addr_o;
  logic [DW-1:0] buf_rd_data_i;
  logic          weight_clr_o, weight_vld_o, ifmap_vld_o, ifmap_row_o;
  logic [OW-1:0] weight_o, ifmap_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int monRel;
  logic logOn = 1'b0;

  logic [DW-1:0] mem [1024];

  logic [OW-1:0] gotW[$], gotP[$], expW[$], expP[$];
  logic          gotRow[$], expRow[$];
  logic [AW-1:0] gotAddr[$], expAddr[$];
  int clrCnt, clrRel, doneCnt, doneRel, busyCnt, busyFirst, overlap;
  int firstW, lastW, firstP, lastP;
  bit rdAt[2048];
  bit ivldAt[2048];

  ifmap_feeder #(
    .G_BUF_ADDR_WIDTH(AW), .G_BUF_DATA_WIDTH(DW), .G_TOP_BITS(TOP),
    .G_BOT_BITS(BOT), .G_KERNEL_SIZE(K), .G_IMAGE_HEIGHT(H), .G_IMAGE_WIDTH(W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .wgt_base_i(wgt_base_i), .ifmap_base_i(ifmap_base_i), .stall_i(stall_i),
    .busy_o(busy_o), .done_o(done_o), .buf_rd_en_o(buf_rd_en_o),
    .buf_rd_addr_o(buf_rd_addr_o), .buf_rd_data_i(buf_rd_data_i),
    .weight_clr_o(weight_clr_o), .weight_vld_o(weight_vld_o), .weight_o(weight_o),
    .ifmap_vld_o(ifmap_vld_o), .ifmap_row_o(ifmap_row_o), .ifmap_o(ifmap_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Global buffer: one-cycle read latency.
  always @(posedge clk) if (buf_rd_en_o) buf_rd_data_i <= mem[buf_rd_addr_o];

  // Observe the DUT mid-cycle and log everything relative to the start cycle.
  always @(negedge clk) begin
    if (logOn) begin
      monRel = cyc - startCyc;
      if (weight_clr_o) begin clrCnt++; clrRel = monRel; end
      if (done_o) begin doneCnt++; doneRel = monRel; end
      if (busy_o) begin busyCnt++; if (busyFirst < 0) busyFirst = monRel; end
      if (weight_vld_o && ifmap_vld_o) overlap++;
      if (buf_rd_en_o) begin
        gotAddr.push_back(buf_rd_addr_o);
        if (monRel >= 0 && monRel < 2048) rdAt[monRel] = 1'b1;
      end
      if (weight_vld_o) begin
        gotW.push_back(weight_o);
        if (firstW < 0) firstW = monRel;
        lastW = monRel;
      end
      if (ifmap_vld_o) begin
        gotP.push_back(ifmap_o);
        gotRow.push_back(ifmap_row_o);
        if (firstP < 0) firstP = monRel;
        lastP = monRel;
        if (monRel >= 0 && monRel < 2048) ivldAt[monRel] = 1'b1;
      end
    end
  end

  function automatic logic [OW-1:0] wConv(input logic [DW-1:0] b);
    int v;
    v = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
    return OW'(v * (1 << (BOT - DW + 1)));
  endfunction

  function automatic logic [OW-1:0] pConv(input logic [DW-1:0] b);
    return OW'(int'(b) * (1 << (BOT - DW)));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fillMem();
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
  endtask

  task automatic clearLog();
    gotW.delete(); gotP.delete(); gotRow.delete(); gotAddr.delete();
    clrCnt = 0; clrRel = -1; doneCnt = 0; doneRel = -1;
    busyCnt = 0; busyFirst = -1; overlap = 0;
    firstW = -1; lastW = -1; firstP = -1; lastP = -1;
    for (int i = 0; i < 2048; i++) begin rdAt[i] = 1'b0; ivldAt[i] = 1'b0; end
  endtask

  task automatic buildModel(input logic [AW-1:0] wb, input logic [AW-1:0] ib);
    int a;
    expW.delete(); expP.delete(); expRow.delete(); expAddr.delete();
    for (int k = 0; k < K; k++) begin
      a = (int'(wb) + k) % (1 << AW);
      expAddr.push_back(AW'(a));
      expW.push_back(wConv(mem[AW'(a)]));
    end
    for (int i = 0; i < NPIX; i++) begin
      a = (int'(ib) + i) % (1 << AW);
      expAddr.push_back(AW'(a));
      expP.push_back(pConv(mem[AW'(a)]));
      expRow.push_back(((i / W) % 2) == 0);
    end
  endtask

  // Runs one job; negative stallAt/busyStartAt/abortAt disable those events.
  task automatic applyStimulus(input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                               input int stallAt, input int stallLen,
                               input int busyStartAt, input int abortAt);
    int rel;
    clearLog();
    buildModel(wb, ib);
    @(posedge clk); #1;
    wgt_base_i = wb;
    ifmap_base_i = ib;
    start_i = 1'b1;
    startCyc = cyc;
    logOn = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rel = cyc - startCyc;
      start_i = (rel == busyStartAt);
      if (rel == busyStartAt) begin
        wgt_base_i = wb + 10'd3;
        ifmap_base_i = ib + 10'd7;
      end
      stall_i = (stallAt >= 0) && (rel >= stallAt) && (rel < stallAt + stallLen);
      if (rel == abortAt) begin
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("abortCtl", {25'd0, busy_o, done_o, buf_rd_en_o, weight_clr_o,
                                 weight_vld_o, ifmap_vld_o, ifmap_row_o}, 32'd0);
        checkOutput("abortAddr", buf_rd_addr_o, 32'd0);
        checkOutput("abortWeight", weight_o, 32'd0);
        checkOutput("abortIfmap", ifmap_o, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        break;
      end
      if (doneCnt > 0 && rel >= doneRel + 2) break;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    logOn = 1'b0;
  endtask

  task automatic verifyJob(input int stallAt, input int stallLen);
    int n, gap;
    checkOutput("clrCount", clrCnt, 1);
    checkOutput("clrCycle", clrRel, 1);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("doneCycle", doneRel, JOBLEN + stallLen);
    checkOutput("busyCycles", busyCnt, JOBLEN + stallLen);
    checkOutput("busyFirst", busyFirst, 1);
    checkOutput("vldOverlap", overlap, 0);
    checkOutput("wFirst", firstW, 4);
    checkOutput("wLast", lastW, 4 + K - 1);
    checkOutput("pFirst", firstP, 4 + K);
    checkOutput("pLast", lastP, 4 + K + NPIX - 1 + stallLen);
    checkOutput("wCount", gotW.size(), K);
    n = (gotW.size() < K) ? gotW.size() : K;
    for (int i = 0; i < n; i++) checkOutput($sformatf("weight%0d", i), gotW[i], expW[i]);
    checkOutput("pCount", gotP.size(), NPIX);
    n = (gotP.size() < NPIX) ? gotP.size() : NPIX;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("pix%0d", i), gotP[i], expP[i]);
      checkOutput($sformatf("row%0d", i), gotRow[i], expRow[i]);
    end
    if (n == NPIX) checkOutput("lastRowFlag", gotRow[NPIX-1], 0);
    checkOutput("addrCount", gotAddr.size(), K + NPIX);
    n = (gotAddr.size() < K + NPIX) ? gotAddr.size() : K + NPIX;
    for (int i = 0; i < n; i++) checkOutput($sformatf("addr%0d", i), gotAddr[i], expAddr[i]);
    if (stallLen > 0) begin
      gap = 0;
      for (int i = stallAt; i < stallAt + stallLen; i++) gap += int'(rdAt[i]);
      checkOutput("stallReads", gap, 0);
      gap = 0;
      for (int i = stallAt + 2; i < stallAt + 2 + stallLen; i++) gap += int'(ivldAt[i]);
      checkOutput("stallGap", gap, 0);
      checkOutput("gapBefore", ivldAt[stallAt + 1], 1);
      checkOutput("gapAfter", ivldAt[stallAt + 2 + stallLen], 1);
    end
  endtask

  int wrapExp[5] = '{1020, 1021, 1022, 1023, 0};

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    wgt_base_i = '0; ifmap_base_i = '0;
    fillMem();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstCtl", {25'd0, busy_o, done_o, buf_rd_en_o, weight_clr_o,
                           weight_vld_o, ifmap_vld_o, ifmap_row_o}, 32'd0);
    checkOutput("rstAddr", buf_rd_addr_o, 32'd0);
    checkOutput("rstWeight", weight_o, 32'd0);
    checkOutput("rstIfmap", ifmap_o, 32'd0);
    rst_i = 1'b0;

    // Directed conversion values on top of random image data.
    mem[100] = 8'h80; mem[101] = 8'h7F; mem[102] = 8'h00; mem[103] = 8'hFF; mem[104] = 8'h01;
    mem[200] = 8'hFF; mem[201] = 8'h80;
    applyStimulus(10'd100, 10'd200, -1, 0, -1, -1);
    verifyJob(-1, 0);
    if (gotW.size() >= K && gotP.size() >= 2) begin
      checkOutput("wConst0", gotW[0], 32'hC000);
      checkOutput("wConst1", gotW[1], 32'h3F80);
      checkOutput("wConst2", gotW[2], 32'h0000);
      checkOutput("wConst3", gotW[3], 32'hFF80);
      checkOutput("wConst4", gotW[4], 32'h0080);
      checkOutput("pConst0", gotP[0], 32'h3FC0);
      checkOutput("pConst1", gotP[1], 32'h2000);
    end else begin
      checkOutput("constStreams", gotW.size() + gotP.size(), K + NPIX);
    end

    // Stall mid-image plus an ignored start pulse while busy.
    fillMem();
    applyStimulus(AW'($urandom), 10'd300, 200, 3, 100, -1);
    verifyJob(200, 3);

    // Address wrap on both weight and image regions.
    fillMem();
    applyStimulus(10'd1022, 10'd1020, -1, 0, -1, -1);
    verifyJob(-1, 0);
    if (gotAddr.size() >= K + 5) begin
      for (int i = 0; i < 5; i++) checkOutput($sformatf("wrapAddr%0d", i), gotAddr[K + i], wrapExp[i]);
    end else begin
      checkOutput("wrapAddrCount", gotAddr.size(), K + NPIX);
    end

    // Asynchronous reset mid-image, then a clean replay.
    fillMem();
    applyStimulus(AW'($urandom), AW'($urandom), -1, 0, -1, 300);
    fillMem();
    applyStimulus(AW'($urandom), AW'($urandom), -1, 0, -1, -1);
    verifyJob(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
